// File: rtl/oisc_com_uart.sv
// oisc_com_uart: memory-mapped 8N1 UART responder on the CPU com port.
// Optional COM_UART_LOOPBACK_EN: CTRL bit2 routes the TX line into RX.
module oisc_com_uart #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         BAUD_DIV   = 434,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] com_addr,
  input  logic [7:0] com_wr,
  input  logic       com_wr_en,
  input  logic       com_rd_en,
  output logic [7:0] com_rd,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [AW:0]   P_ONE    = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

  logic hit_data, hit_stat, hit_ctrl;
  logic wr_ctrl, clr_ovr, flush;
  logic [7:0] ctrl_rd;

  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp;
  logic tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0] tx_head;

  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp, rx_rp;
  logic rx_empty, rx_full, rx_push, rx_pop;

  st_t tx_st, tx_nxt, rx_st, rx_nxt;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_sr, rx_sr;
  logic tx_end, tx_bit_val, tx_line;
  logic rx_end, rx_done, ovr_set;
  logic rx_in, rx_s1, rx_s2, rx_d;
  logic overrun;

  assign hit_data = (com_addr == BASE_ADDR);
  assign hit_stat = (com_addr == BASE_ADDR + 8'd1);
  assign hit_ctrl = (com_addr == BASE_ADDR + 8'd2);
  assign wr_ctrl  = com_wr_en && hit_ctrl;
  assign clr_ovr  = wr_ctrl && com_wr[0];
  assign flush    = wr_ctrl && com_wr[1];

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];
  assign tx_push  = com_wr_en && hit_data && !tx_full;
  assign rx_pop   = com_rd_en && hit_data && !rx_empty;
  assign irq      = !rx_empty || overrun;

`ifdef COM_UART_LOOPBACK_EN
  logic loop_en;
  assign ctrl_rd = {5'b00000, loop_en, 2'b00};
  assign rx_in   = loop_en ? tx_line : uart_rx;
  assign uart_tx = loop_en ? 1'b1 : tx_line;

  // Loopback enable bit, written through CTRL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) loop_en <= 1'b0;
    else if (wr_ctrl) loop_en <= com_wr[2];
  end
`else
  assign ctrl_rd = 8'h00;
  assign rx_in   = uart_rx;
  assign uart_tx = tx_line;
`endif

  // Register read mux
  always_comb begin
    com_rd = 8'h00;
    unique case (1'b1)
      hit_data: com_rd = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
      hit_stat: com_rd = {3'b000, overrun, rx_full,
                          rx_empty, tx_empty, tx_full};
      hit_ctrl: com_rd = ctrl_rd;
      default:  com_rd = 8'h00;
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= com_wr;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
  end

  // FIFO pointers; flush beats any same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0;
      rx_wp <= '0; rx_rp <= '0;
    end else if (flush) begin
      tx_wp <= '0; tx_rp <= '0;
      rx_wp <= '0; rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + P_ONE;
      if (tx_pop)  tx_rp <= tx_rp + P_ONE;
      if (rx_push) rx_wp <= rx_wp + P_ONE;
      if (rx_pop)  rx_rp <= rx_rp + P_ONE;
    end
  end

  // Sticky overrun; a new overrun beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

  // TX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_st <= S_IDLE;
    else tx_st <= tx_nxt;
  end

  assign tx_end = (tx_cnt == BIT_END);

  // TX next state
  always_comb begin
    tx_nxt = tx_st;
    unique case (tx_st)
      S_IDLE:  if (!tx_empty) tx_nxt = S_START;
      S_START: if (tx_end) tx_nxt = S_DATA;
      S_DATA:  if (tx_end && tx_bit == 3'd7) tx_nxt = S_STOP;
      S_STOP:  if (tx_end) tx_nxt = tx_empty ? S_IDLE : S_START;
      default: tx_nxt = S_IDLE;
    endcase
  end

  // TX outputs: FIFO pop and current line level
  always_comb begin
    tx_pop = 1'b0;
    tx_bit_val = 1'b1;
    unique case (tx_st)
      S_IDLE:  tx_pop = !tx_empty;
      S_START: tx_bit_val = 1'b0;
      S_DATA:  tx_bit_val = tx_sr[0];
      S_STOP:  tx_pop = tx_end && !tx_empty;
      default: tx_bit_val = 1'b1;
    endcase
  end

  // TX datapath: baud counter, shifter, registered line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= '0; tx_bit <= '0;
      tx_sr <= '0; tx_line <= 1'b1;
    end else begin
      tx_line <= tx_bit_val;
      if (tx_st == S_IDLE || tx_end) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + C_ONE;
      if (tx_pop) begin
        tx_sr <= tx_head;
        tx_bit <= '0;
      end else if (tx_st == S_DATA && tx_end) begin
        tx_sr <= {1'b0, tx_sr[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
    end
  end

  // RX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_st <= S_IDLE;
    else rx_st <= rx_nxt;
  end

  assign rx_end = (rx_st == S_START) ? (rx_cnt == HALF_END)
                                     : (rx_cnt == BIT_END);

  // RX next state; start bit rechecked at half a bit
  always_comb begin
    rx_nxt = rx_st;
    unique case (rx_st)
      S_IDLE:  if (rx_d && !rx_s2) rx_nxt = S_START;
      S_START: if (rx_end) rx_nxt = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_end && rx_bit == 3'd7) rx_nxt = S_STOP;
      S_STOP:  if (rx_end) rx_nxt = S_IDLE;
      default: rx_nxt = S_IDLE;
    endcase
  end

  // RX outputs: push a good byte or flag overrun
  always_comb begin
    rx_done = (rx_st == S_STOP) && rx_end;
    rx_push = rx_done && rx_s2 && !rx_full;
    ovr_set = rx_done && rx_s2 && rx_full;
  end

  // RX datapath: synchroniser, baud counter, shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_d <= 1'b1;
      rx_cnt <= '0; rx_bit <= '0; rx_sr <= '0;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      if (rx_st == S_IDLE || rx_end) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + C_ONE;
      if (rx_st == S_START) rx_bit <= '0;
      else if (rx_st == S_DATA && rx_end) begin
        rx_sr <= {rx_s2, rx_sr[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_oisc_com_uart.sv
// tb_oisc_com_uart: directed bench for the com-port UART.
// TX frames are decoded from uart_tx and checked against a queue.
module tb_oisc_com_uart;
  localparam logic [7:0] BASE   = 8'h10;
  localparam int         BD     = 4;
  localparam int         DEPTH  = 16;
  localparam logic [7:0] A_DATA = BASE;
  localparam logic [7:0] A_STAT = BASE + 8'd1;
  localparam logic [7:0] A_CTRL = BASE + 8'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] com_addr = 8'h00;
  logic [7:0] com_wr = 8'h00;
  logic       com_wr_en = 1'b0;
  logic       com_rd_en = 1'b0;
  logic [7:0] com_rd;
  logic       uart_tx;
  logic       uart_rx = 1'b1;
  logic       irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  oisc_com_uart #(
    .BASE_ADDR(BASE), .BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .com_addr(com_addr), .com_wr(com_wr),
    .com_wr_en(com_wr_en), .com_rd_en(com_rd_en),
    .com_rd(com_rd), .uart_tx(uart_tx),
    .uart_rx(uart_rx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check8(input string n, input logic [7:0] got,
                        input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic checkint(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  // Scoreboard of bytes expected on uart_tx
  logic [7:0] tx_exp[$];
  int tx_starts[$];
  int frames_seen = 0;
  int rst_cnt = 0;
  int mon_st, mon_rc;
  logic [9:0] mon_fr;
  logic [7:0] mon_e;

  always @(posedge rst) rst_cnt++;

  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        mon_st = cyc;
        mon_rc = rst_cnt;
        for (int i = 0; i < 10; i++) begin
          repeat ((i == 0) ? 2 : BD) @(negedge clk);
          mon_fr[i] = uart_tx;
        end
        if (mon_rc == rst_cnt) begin
          frames_seen++;
          tx_starts.push_back(mon_st);
          checks++;
          if (mon_fr[0] !== 1'b0 || mon_fr[9] !== 1'b1) begin
            failures++;
            $display("FAIL tx_framing got=%b%b exp=01",
                     mon_fr[0], mon_fr[9]);
          end
          if (tx_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected got=%h exp=none", mon_fr[8:1]);
          end else begin
            mon_e = tx_exp.pop_front();
            check8("tx_byte", mon_fr[8:1], mon_e);
          end
        end
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    com_addr = a; com_wr = d; com_wr_en = 1'b1;
    @(posedge clk); #1;
    com_wr_en = 1'b0; com_addr = 8'h00; com_wr = 8'h00;
  endtask

  task automatic rd_chk(input string n, input logic [7:0] a,
                        input logic pop, input logic [7:0] exp);
    logic [7:0] v;
    com_addr = a; com_rd_en = pop;
    @(negedge clk);
    v = com_rd;
    @(posedge clk); #1;
    com_addr = 8'h00; com_rd_en = 1'b0;
    check8(n, v, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_frames(input string n, input int target,
                             input int budget);
    int k = 0;
    while (frames_seen < target && k < budget) begin
      @(posedge clk); k++;
    end
    #1;
    checkint(n, frames_seen, target);
  endtask

  task automatic wait_irq(input string n, input int budget);
    int k = 0;
    while (irq !== 1'b1 && k < budget) begin
      @(posedge clk); k++;
    end
    #1;
    check8(n, {7'd0, irq}, 8'h01);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int base, w;
    repeat (3) @(posedge clk);
    #1;
    check8("rst_tx", {7'd0, uart_tx}, 8'h01);
    check8("rst_irq", {7'd0, irq}, 8'h00);
    check8("rst_rd", com_rd, 8'h00);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("stat_reset", A_STAT, 1'b0, 8'h06);
    rd_chk("ctrl_reset", A_CTRL, 1'b0, 8'h00);
    rd_chk("data_empty", A_DATA, 1'b1, 8'h00);

    // Single TX byte and its latency
    base = frames_seen;
    tx_exp.push_back(8'hA5);
    wr(A_DATA, 8'hA5);
    w = cyc;
    wait_frames("tx_a5_done", base + 1, 100);
    checkint("tx_latency", tx_starts[base] - w, 2);
    repeat (4) @(posedge clk); #1;
    rd_chk("stat_after_tx", A_STAT, 1'b0, 8'h06);

    // Single RX byte
    send_rx(8'h3C, 1'b1);
    wait_irq("rx_irq_rise", 20);
    rd_chk("stat_rx", A_STAT, 1'b0, 8'h02);
    rd_chk("rx_data", A_DATA, 1'b1, 8'h3C);
    rd_chk("stat_rx_pop", A_STAT, 1'b0, 8'h06);
    check8("rx_irq_fall", {7'd0, irq}, 8'h00);

    // Framing error is discarded
    send_rx(8'h77, 1'b0);
    repeat (10) @(posedge clk); #1;
    rd_chk("stat_frame_err", A_STAT, 1'b0, 8'h06);

    // Pop and push in the same cycle
    send_rx(8'h81, 1'b1);
    wait_irq("combo_irq", 20);
    base = frames_seen;
    tx_exp.push_back(8'h66);
    com_addr = A_DATA; com_wr = 8'h66;
    com_wr_en = 1'b1; com_rd_en = 1'b1;
    @(negedge clk);
    check8("combo_rd", com_rd, 8'h81);
    @(posedge clk); #1;
    com_addr = 8'h00; com_wr_en = 1'b0; com_rd_en = 1'b0;
    rd_chk("stat_combo", A_STAT, 1'b0, 8'h04);
    wait_frames("combo_tx_done", base + 1, 100);

    // RX overrun with a full FIFO
    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'(i + 1), 1'b1);
    repeat (4) @(posedge clk); #1;
    rd_chk("stat_ovr", A_STAT, 1'b0, 8'h1A);
    rd_chk("ovr_rd0", A_DATA, 1'b1, 8'h01);
    rd_chk("ovr_rd1", A_DATA, 1'b1, 8'h02);
    wr(A_CTRL, 8'h01);
    rd_chk("stat_ovr_clr", A_STAT, 1'b0, 8'h02);
    wr(A_CTRL, 8'h02);
    rd_chk("stat_flush", A_STAT, 1'b0, 8'h06);
    rd_chk("data_flushed", A_DATA, 1'b1, 8'h00);
    check8("flush_irq", {7'd0, irq}, 8'h00);

    // Decode miss and ignored STATUS write
    send_rx(8'h42, 1'b1);
    wait_irq("dec_irq", 20);
    com_addr = BASE + 8'd3; com_wr = 8'h03;
    com_wr_en = 1'b1; com_rd_en = 1'b1;
    @(negedge clk);
    check8("dec_miss_rd", com_rd, 8'h00);
    @(posedge clk); #1;
    com_addr = 8'h00; com_wr_en = 1'b0; com_rd_en = 1'b0;
    wr(A_STAT, 8'hFF);
    rd_chk("dec_stat", A_STAT, 1'b0, 8'h02);
    rd_chk("dec_data", A_DATA, 1'b1, 8'h42);

    // TX full while busy, then back-to-back frames
    base = frames_seen;
    tx_exp.push_back(8'h11);
    wr(A_DATA, 8'h11);
    repeat (5) @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) begin
      tx_exp.push_back(8'(8'h80 + i));
      wr(A_DATA, 8'(8'h80 + i));
    end
    rd_chk("stat_tx_full", A_STAT, 1'b0, 8'h05);
    wr(A_DATA, 8'hEE);
    wait_frames("tx_burst_done", base + DEPTH + 1, 1000);
    repeat (60) @(posedge clk); #1;
    checkint("tx_frames_total", frames_seen, base + DEPTH + 1);
    checkint("tx_queue_drained", tx_exp.size(), 0);
    for (int i = 1; i <= DEPTH; i++)
      checkint("tx_gap", tx_starts[base + i] - tx_starts[base + i - 1],
               10 * BD);

    // Reset in the middle of a TX frame
    base = frames_seen;
    wr(A_DATA, 8'hC3);
    wr(A_DATA, 8'h3C);
    wr(A_DATA, 8'h55);
    check8("tx_low_pre_rst", {7'd0, uart_tx}, 8'h00);
    #2 rst = 1'b1;
    #1;
    check8("tx_async_rst", {7'd0, uart_tx}, 8'h01);
    rd_chk("stat_in_rst", A_STAT, 1'b0, 8'h06);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check8("irq_after_rst", {7'd0, irq}, 8'h00);
    repeat (60) @(posedge clk); #1;
    checkint("no_tx_after_rst", frames_seen, base);
    rd_chk("stat_after_rst", A_STAT, 1'b0, 8'h06);

`ifdef COM_UART_LOOPBACK_EN
    // Internal loopback keeps the pin idle
    wr(A_CTRL, 8'h04);
    rd_chk("ctrl_loop", A_CTRL, 1'b0, 8'h04);
    wr(A_DATA, 8'h5A);
    wait_irq("lb_irq", 200);
    rd_chk("lb_stat", A_STAT, 1'b0, 8'h02);
    rd_chk("lb_data", A_DATA, 1'b1, 8'h5A);
    repeat (10) @(posedge clk); #1;
    checkint("lb_no_pin_tx", frames_seen, base);
    wr(A_CTRL, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
